// File: rtl/fifo_pkg.sv
// Shared sizing helpers and defaults for the single-clock FIFO family.
package fifo_pkg;

    localparam int unsigned RST_DO_DEFAULT = 0;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    function automatic int unsigned ptr_w(input int unsigned aw);
        return aw + 1;
    endfunction

    function automatic int unsigned depth(input int unsigned aw);
        return 32'(1) << aw;
    endfunction

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Handshake, status and configuration bundle for sync_fifo_ctrl.
// The read-data signal is named dout because do is a reserved word.
interface sync_fifo_ctrl_if
    import fifo_pkg::*;
#(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 3
);
    localparam int unsigned PW = ptr_w(AW);

    logic          wr_en;
    logic [DW-1:0] di;
    logic          rd_en;
    logic [DW-1:0] dout;
    logic          do_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [PW-1:0] count;
    logic [PW-1:0] af_thresh;
    logic [PW-1:0] ae_thresh;
    logic          overflow;
    logic          underflow;
    logic          clr_err;

    modport master (
        output wr_en, di, rd_en, af_thresh, ae_thresh, clr_err,
        input  dout, do_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, di, rd_en, af_thresh, ae_thresh, clr_err,
        output dout, do_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/fifo_storage.sv
// Simple dual-port array: one write port, one registered read port with enable.
module fifo_storage
    import fifo_pkg::*;
#(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    localparam int unsigned DEPTH = depth(AW);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;

    // Array and read register are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO: pointers, occupancy, thresholds and sticky error flags.
// Define FWFT_EN for first-word-fall-through output; default is registered read.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned   DW     = 8,
    parameter int unsigned   AW     = 3,
    parameter logic [DW-1:0] RST_DO = DW'(RST_DO_DEFAULT)
) (
    input logic             clk,
    input logic             rst,
    sync_fifo_ctrl_if.slave bus
);
    localparam int unsigned PW    = ptr_w(AW);
    localparam int unsigned DEPTH = depth(AW);

    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DW-1:0] byp_q, byp_d;
    logic          src_arr_q, src_arr_d;
    logic          do_valid_q, do_valid_d;
    logic          ovf_q, ovf_d, unf_q, unf_d;

    logic          mem_we, mem_re, wr_acc;
    logic [DW-1:0] mem_rdata;
    logic [PW-1:0] arr_cnt, count_c;
    logic          arr_empty, full_c, empty_c;

    assign arr_cnt   = wptr_q - rptr_q;
    assign arr_empty = (wptr_q == rptr_q);

`ifdef FWFT_EN
    logic pop, ld;

    // Occupancy includes the word parked in the output register.
    assign count_c = arr_cnt + PW'(do_valid_q);
    assign full_c  = (count_c == PW'(DEPTH));
    assign empty_c = !do_valid_q;
`else
    assign count_c = arr_cnt;
    assign full_c  = ((wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}});
    assign empty_c = arr_empty;
`endif

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        byp_d      = byp_q;
        src_arr_d  = src_arr_q;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        wr_acc     = bus.wr_en && !full_c;
`ifdef FWFT_EN
        do_valid_d = do_valid_q;
        pop        = bus.rd_en && do_valid_q;
        ld         = !do_valid_q || pop;
        // Refill the head from the array, or straight from di when the array is empty.
        if (ld) begin
            if (!arr_empty) begin
                mem_re     = 1'b1;
                rptr_d     = rptr_q + PW'(1);
                src_arr_d  = 1'b1;
                do_valid_d = 1'b1;
            end else if (wr_acc) begin
                byp_d      = bus.di;
                src_arr_d  = 1'b0;
                do_valid_d = 1'b1;
            end else begin
                do_valid_d = 1'b0;
            end
        end
        if (wr_acc && !(ld && arr_empty)) begin
            mem_we = 1'b1;
            wptr_d = wptr_q + PW'(1);
        end
`else
        do_valid_d = 1'b0;
        if (bus.rd_en && !empty_c) begin
            mem_re     = 1'b1;
            rptr_d     = rptr_q + PW'(1);
            src_arr_d  = 1'b1;
            do_valid_d = 1'b1;
        end
        if (wr_acc) begin
            mem_we = 1'b1;
            wptr_d = wptr_q + PW'(1);
        end
`endif
        // Set wins over clear.
        ovf_d = (ovf_q && !bus.clr_err) || (bus.wr_en && full_c);
        unf_d = (unf_q && !bus.clr_err) || (bus.rd_en && empty_c);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            byp_q      <= RST_DO;
            src_arr_q  <= 1'b0;
            do_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            byp_q      <= byp_d;
            src_arr_q  <= src_arr_d;
            do_valid_q <= do_valid_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    fifo_storage #(.DW(DW), .AW(AW)) u_storage (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wptr_q[AW-1:0]),
        .wdata (bus.di),
        .re    (mem_re),
        .raddr (rptr_q[AW-1:0]),
        .rdata (mem_rdata)
    );

    // Until the first array read after reset, dout shows the reset/bypass word.
    assign bus.dout         = src_arr_q ? mem_rdata : byp_q;
    assign bus.do_valid     = do_valid_q;
    assign bus.full         = full_c;
    assign bus.empty        = empty_c;
    assign bus.count        = count_c;
    assign bus.almost_full  = (count_c >= bus.af_thresh);
    assign bus.almost_empty = (count_c <= bus.ae_thresh);
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;

endmodule
